// File: rtl/seq_mul_unit_pkg.sv
// rtl/seq_mul_unit_pkg.sv - shared state type and width helpers for the sequential multiplier
package mul_pkg;

   typedef enum logic [1:0] {IDLE, CALC, DONE} mul_state_t;

   function automatic int prod_width(input int w);
      return 2 * w;
   endfunction

   function automatic int clog2(input int v);
      return $clog2(v);
   endfunction

endpackage

// File: rtl/seq_mul_unit_if.sv
// rtl/seq_mul_unit_if.sv - operand/product handshake bundle for seq_mul_unit
interface seq_mul_unit_if #(
   parameter int WIDTH = 5
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 signed_mode;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   p;
   logic                 ovf;
   logic                 zero;

   modport master (
      output in_valid, a, b, signed_mode, out_ready,
      input  in_ready, out_valid, p, ovf, zero
   );

   modport slave (
      input  in_valid, a, b, signed_mode, out_ready,
      output in_ready, out_valid, p, ovf, zero
   );
endinterface

// File: rtl/seq_mul_unit_cond_negate.sv
// rtl/seq_mul_unit_cond_negate.sv - conditional two's complement negation
module cond_negate #(
   parameter int N = 8
) (
   input  logic         neg,
   input  logic [N-1:0] x,
   output logic [N-1:0] y
);
   assign y = neg ? (~x + N'(1)) : x;
endmodule

// File: rtl/seq_mul_unit.sv
// rtl/seq_mul_unit.sv - iterative shift-add multiplier, signed/unsigned, valid/ready on both sides
module seq_mul_unit
   import mul_pkg::*;
#(
   parameter int WIDTH     = 5,
   parameter int ZERO_SKIP = 1
) (
   input logic           clk,
   input logic           rst,
   seq_mul_unit_if.slave bus
);
   localparam int PW = prod_width(WIDTH);
   localparam int CW = clog2(WIDTH + 1);

   mul_state_t       state_q, state_d;
   logic [CW-1:0]    cnt_q;
   logic [PW-1:0]    acc_q, mcand_q, acc_d, p_d, p_q;
   logic [WIDTH-1:0] mplier_q, mag_a, mag_b;
   logic             mode_q, neg_q, ovf_q, zero_q, ovf_d;
   logic             zero_op, skip, last;

   cond_negate #(.N(WIDTH)) u_mag_a (
      .neg(bus.signed_mode & bus.a[WIDTH-1]), .x(bus.a), .y(mag_a)
   );
   cond_negate #(.N(WIDTH)) u_mag_b (
      .neg(bus.signed_mode & bus.b[WIDTH-1]), .x(bus.b), .y(mag_b)
   );

   // Multiplicand and multiplier are shifted in place, so bit cnt is always at mplier_q[0].
   assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

   cond_negate #(.N(PW)) u_prod (.neg(neg_q), .x(acc_d), .y(p_d));

   assign ovf_d   = mode_q ? ~((&p_d[PW-1:WIDTH-1]) | ~(|p_d[PW-1:WIDTH-1]))
                           : (|p_d[PW-1:WIDTH]);
   assign zero_op = (bus.a == '0) || (bus.b == '0);
   assign skip    = (ZERO_SKIP != 0) && zero_op;
   assign last    = (cnt_q == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_d = skip ? DONE : CALC;
         end
         CALC: if (last) state_d = DONE;
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         mode_q   <= 1'b0;
         neg_q    <= 1'b0;
         p_q      <= '0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else if (state_q == IDLE && bus.in_valid) begin
         mode_q   <= bus.signed_mode;
         neg_q    <= bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
         mcand_q  <= PW'(mag_a);
         mplier_q <= mag_b;
         acc_q    <= '0;
         cnt_q    <= '0;
         if (skip) begin
            p_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b1;
         end
      end else if (state_q == CALC) begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + CW'(1);
         if (last) begin
            p_q    <= p_d;
            ovf_q  <= ovf_d;
            zero_q <= (p_d == '0);
         end
      end
   end

   assign bus.p    = p_q;
   assign bus.ovf  = ovf_q;
   assign bus.zero = zero_q;
endmodule

// File: tb/tb_seq_mul_unit.sv
// tb/tb_seq_mul_unit.sv - scoreboard bench for seq_mul_unit (W5 skip, W5 no-skip, W8 skip)
module tb_seq_mul_unit;
   import mul_pkg::*;

   typedef struct {
      logic [15:0] p;
      bit          ovf;
      bit          zero;
      int          lat;
   } exp_t;

   logic clk, rst;
   logic iv, sm, ordy;
   logic [7:0] ta, tbv;
   int sel, or_mode;
   int n_chk, n_fail;
   int cyc, acc_cyc;
   exp_t exp_q[$];

   logic        m_ir, m_ov, m_ovf, m_zero;
   logic [15:0] m_p;

   seq_mul_unit_if #(.WIDTH(5)) i5  ();
   seq_mul_unit_if #(.WIDTH(5)) i5n ();
   seq_mul_unit_if #(.WIDTH(8)) i8  ();

   seq_mul_unit #(.WIDTH(5), .ZERO_SKIP(1)) u_dut5  (.clk(clk), .rst(rst), .bus(i5));
   seq_mul_unit #(.WIDTH(5), .ZERO_SKIP(0)) u_dut5n (.clk(clk), .rst(rst), .bus(i5n));
   seq_mul_unit #(.WIDTH(8), .ZERO_SKIP(1)) u_dut8  (.clk(clk), .rst(rst), .bus(i8));

   assign i5.in_valid     = iv && (sel == 0);
   assign i5.a            = ta[4:0];
   assign i5.b            = tbv[4:0];
   assign i5.signed_mode  = sm;
   assign i5.out_ready    = ordy;
   assign i5n.in_valid    = iv && (sel == 1);
   assign i5n.a           = ta[4:0];
   assign i5n.b           = tbv[4:0];
   assign i5n.signed_mode = sm;
   assign i5n.out_ready   = ordy;
   assign i8.in_valid     = iv && (sel == 2);
   assign i8.a            = ta;
   assign i8.b            = tbv;
   assign i8.signed_mode  = sm;
   assign i8.out_ready    = ordy;

   always_comb begin
      case (sel)
         0: begin
            m_ir = i5.in_ready; m_ov = i5.out_valid; m_p = 16'(i5.p);
            m_ovf = i5.ovf; m_zero = i5.zero;
         end
         1: begin
            m_ir = i5n.in_ready; m_ov = i5n.out_valid; m_p = 16'(i5n.p);
            m_ovf = i5n.ovf; m_zero = i5n.zero;
         end
         default: begin
            m_ir = i8.in_ready; m_ov = i8.out_valid; m_p = i8.p;
            m_ovf = i8.ovf; m_zero = i8.zero;
         end
      endcase
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
      $fatal(1);
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst && iv && m_ir) acc_cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
      end
   endtask

   function automatic int w_of(input int s);
      return (s == 2) ? 8 : 5;
   endfunction

   function automatic bit zs_of(input int s);
      return s != 1;
   endfunction

   function automatic exp_t ref_mul(input int w, input bit zs, input logic [7:0] a,
                                    input logic [7:0] b, input bit smd);
      exp_t  e;
      longint av, bv, pr;
      av = longint'(a) & ((longint'(1) << w) - 1);
      bv = longint'(b) & ((longint'(1) << w) - 1);
      if (smd && a[w-1]) av = av - (longint'(1) << w);
      if (smd && b[w-1]) bv = bv - (longint'(1) << w);
      pr     = av * bv;
      e.p    = 16'(pr & ((longint'(1) << (2 * w)) - 1));
      e.ovf  = smd ? ((pr < -(longint'(1) << (w - 1))) || (pr > (longint'(1) << (w - 1)) - 1))
                   : (pr > (longint'(1) << w) - 1);
      e.zero = (pr == 0);
      e.lat  = (zs && (av == 0 || bv == 0)) ? 1 : w + 1;
      return e;
   endfunction

   initial begin
      ordy = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (or_mode)
            0:       ordy = 1'b1;
            1:       ordy = 1'($urandom_range(0, 1));
            default: ordy = 1'b0;
         endcase
      end
   end

   // Scoreboard side: checks latency, hold stability, result and post-handshake behaviour.
   exp_t        mon_e;
   logic        ov_prev, hs_pend;
   logic [17:0] held_v, last_v;
   initial begin
      ov_prev = 1'b0;
      hs_pend = 1'b0;
      held_v  = '0;
      last_v  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            ov_prev = 1'b0;
            hs_pend = 1'b0;
         end else begin
            if (hs_pend) begin
               check("ov_drop", m_ov, 1'b0);
               check("ir_back", m_ir, 1'b1);
               check("keep", {m_p, m_ovf, m_zero}, last_v);
               hs_pend = 1'b0;
            end
            if (m_ov) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_ov", m_ov, 1'b0);
               end else begin
                  if (!ov_prev) check("latency", cyc - acc_cyc + 1, exp_q[0].lat);
                  else          check("hold", {m_p, m_ovf, m_zero}, held_v);
                  check("busy_ir", m_ir, 1'b0);
                  if (ordy) begin
                     mon_e = exp_q.pop_front();
                     check("p", m_p, mon_e.p);
                     check("ovf", m_ovf, mon_e.ovf);
                     check("zero", m_zero, mon_e.zero);
                     hs_pend = 1'b1;
                     last_v  = {m_p, m_ovf, m_zero};
                  end
               end
            end
            ov_prev = m_ov;
            held_v  = {m_p, m_ovf, m_zero};
         end
      end
   end

   task automatic issue(input int s, input logic [7:0] a, input logic [7:0] bb, input bit smd);
      exp_t e;
      int   n;
      e = ref_mul(w_of(s), zs_of(s), a, bb, smd);
      @(posedge clk);
      #1;
      sel = s; ta = a; tbv = bb; sm = smd; iv = 1'b1;
      n = 0;
      while (1) begin
         @(negedge clk);
         if (m_ir) break;
         n++;
         if (n > 100) begin
            check("accept_timeout", 1'b0, 1'b1);
            iv = 1'b0;
            return;
         end
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      iv = 1'b0; ta = 8'($urandom); tbv = 8'($urandom); sm = 1'($urandom);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || !m_ir) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("drain", (exp_q.size() == 0) && m_ir, 1'b1);
      repeat (10) @(negedge clk);
   endtask

   initial begin
      n_chk = 0; n_fail = 0; cyc = 0; acc_cyc = 0;
      rst = 1'b1; iv = 1'b0; sm = 1'b0; ta = '0; tbv = '0; sel = 0; or_mode = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         check("rst_in_ready", m_ir, 1'b1);
         check("rst_out_valid", m_ov, 1'b0);
         check("rst_p", m_p, 16'd0);
         check("rst_ovf", m_ovf, 1'b0);
         check("rst_zero", m_zero, 1'b0);
      end
      sel = 0;

      issue(0, 8'd31, 8'd31, 1'b0);
      wait_done();
      issue(0, 8'b11101, 8'd7, 1'b1);
      issue(0, 8'b10000, 8'b10000, 1'b1);
      issue(0, 8'b11110, 8'd3, 1'b1);
      wait_done();
      issue(0, 8'd0, 8'd19, 1'b0);
      wait_done();
      issue(1, 8'd0, 8'd19, 1'b0);
      wait_done();

      or_mode = 2;
      issue(0, 8'd12, 8'd10, 1'b0);
      @(posedge clk);
      #1;
      iv = 1'b1; ta = 8'd3; tbv = 8'd3;
      @(negedge clk);
      check("calc_in_ready", m_ir, 1'b0);
      @(posedge clk);
      #1;
      iv = 1'b0;
      begin
         int n;
         n = 0;
         while (!m_ov && n < 50) begin
            @(negedge clk);
            n++;
         end
         check("bp_out_valid", m_ov, 1'b1);
      end
      repeat (4) @(negedge clk);
      or_mode = 0;
      wait_done();

      issue(0, 8'd9, 8'd9, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", m_ov, 1'b0);
      check("midrst_p", m_p, 16'd0);
      check("midrst_in_ready", m_ir, 1'b1);
      repeat (10) @(negedge clk);
      issue(0, 8'd2, 8'd3, 1'b0);
      wait_done();

      or_mode = 1;
      for (int smd = 0; smd < 2; smd++)
         for (int a = 0; a < 32; a++)
            for (int b = 0; b < 32; b++)
               issue(0, 8'(a), 8'(b), 1'(smd));
      wait_done();
      for (int i = 0; i < 40; i++)
         issue(1, 8'($urandom_range(0, 31)), 8'($urandom_range(0, 31)), 1'($urandom));
      wait_done();
      for (int i = 0; i < 300; i++)
         issue(2, ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom),
               8'($urandom), 1'($urandom));
      wait_done();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/seq_mul_unit.md
Name: seq_mul_unit

Overview:
- Parametrised iterative shift-add multiplier for the ALU datapath. It is the successor to the 5x5 combinational array multiplier.
- Computes a 2*WIDTH-bit product of two WIDTH-bit operands, one partial product per clock.
- Supports signed (two's complement) and unsigned modes, plus an optional zero-operand early exit.
- Uses a valid/ready handshake on both input and output, so the ALU can stall it.

Parameters:
- WIDTH, 5, operand width in bits (>=2); the product is 2*WIDTH bits.
- ZERO_SKIP, 1, when 1, an operand equal to zero bypasses iteration.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands and mode are valid
- in_ready  output  1  unit can accept operands (IDLE only)
- a  input  WIDTH  multiplicand
- b  input  WIDTH  multiplier
- signed_mode  input  1  1 = two's complement operands, 0 = unsigned
- out_valid  output  1  product is valid; held until accepted
- out_ready  input  1  consumer accepts the product
- p  output  2*WIDTH  product
- ovf  output  1  product does not fit in WIDTH bits (signed or unsigned per latched mode)
- zero  output  1  p == 0

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset state: state=IDLE; in_ready=1 in the cycle after reset; out_valid=0, p=0, ovf=0, zero=0; all internal registers cleared.
- Reset mid-operation: an in-progress or undelivered product is discarded, no out_valid is produced, and the unit returns to IDLE.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - Accept occurs on the edge where in_valid&in_ready.
  - At accept, latch mode, neg = signed_mode & (a[MSB]^b[MSB]), and magnitudes |a|, |b| (unsigned mode: magnitude = raw value).
  - -2^(WIDTH-1) has magnitude 2^(WIDTH-1); this fits in WIDTH unsigned bits and needs no special case.
  - Clear acc, set cnt=0.
  - If ZERO_SKIP=1 and (a==0 or b==0): go directly to DONE with p=0.
  - Otherwise go to CALC.
- CALC, per cycle:
  - If multiplier bit[cnt]=1: acc += mcand << cnt (2*WIDTH-bit add, no carry out possible).
  - cnt++.
  - After exactly WIDTH CALC cycles, go to DONE.
- DONE:
  - out_valid=1; p = neg ? -acc : acc (2*WIDTH-bit two's complement).
  - zero = (p==0).
  - ovf in unsigned mode: p[2W-1:W] != 0. ovf in signed mode: p[2W-1:W-1] is not all-equal.
  - p, ovf and zero are stable while out_valid=1 and out_ready=0.
  - On out_valid&out_ready, go to IDLE; out_valid falls the next cycle, and p/ovf/zero keep their last values.
- Latency:
  - Normal operation: out_valid is asserted WIDTH+1 clocks after the accept edge.
  - Zero skip: out_valid is asserted 1 clock after the accept edge.
  - Minimum issue interval is WIDTH+2 clocks (no overlap; in_ready=0 in CALC and DONE).
- Handshake rules:
  - in_valid while busy is ignored and the operands are not captured.
  - Operand or mode changes after the accept edge have no effect.
  - out_ready asserted while out_valid=0 is ignored.
- The mode is latched at accept, so ovf and the sign use the latched mode, not the live signed_mode pin.

Decomposition:
- Shared package mul_pkg:
  - state enum mul_state_t {IDLE, CALC, DONE};
  - localparam PW = 2*WIDTH-derived helper;
  - function clog2 for the cnt width ($clog2(WIDTH+1)).
- Sub-module cond_negate #(N): combinational y = neg ? -x : x. It is used for both operand magnitudes (N=WIDTH) and the final product (N=2*WIDTH).
- All remaining logic stays in seq_mul_unit.

Test Plan:
1. Unsigned max: WIDTH=5, signed_mode=0, a=31, b=31, out_ready=1 -> out_valid at 6 clocks after accept; p=961 (10'h3C1), ovf=1, zero=0.
2. Signed mixed: signed_mode=1, a=5'b11101 (-3), b=7 -> p=10'h3EB (-21), ovf=1 (-21 < -16), zero=0.
   Also a=-16, b=-16 -> p=256 (10'h100), ovf=1.
   Also a=-2, b=3 -> p=10'h3FA, ovf=0.
3. Zero skip: ZERO_SKIP=1, a=0, b=19 -> out_valid 1 clock after accept, p=0, zero=1, ovf=0.
   With ZERO_SKIP=0, the same stimulus -> out_valid at 6 clocks, p=0.
4. Backpressure: a=12, b=10 with out_ready=0 for 4 cycles after out_valid -> p=120 held stable, in_ready=0 throughout.
   Raising out_ready -> out_valid drops next cycle, in_ready=1.
   A second in_valid pulse during CALC is not captured (the next result still equals 120).
5. Reset mid-op: accept a=9, b=9, assert rst on the 3rd CALC cycle -> next cycle state IDLE, out_valid=0, p=0, in_ready=1.
   No product is ever presented; a subsequent a=2, b=3 gives p=6.
6. Randomised sweep, WIDTH=5 exhaustive and WIDTH=8 random, both modes, random out_ready: p matches the reference product, ovf/zero match their definitions, and latency matches the rule above.
